alu_dispatch: RTL and testbench

ALU_DISPATCH -- requirements
Module: alu_dispatch

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_dispatch_fifo.sv | 47 ++++
 rtl/alu_dispatch.sv | 123 ++++++++++++
 tb/tb_alu_dispatch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map and FSM state encoding for the ALU dispatcher and the ALU it drives.
package alu_pkg;

  localparam int unsigned OP_AND  = 0;
  localparam int unsigned OP_OR   = 1;
  localparam int unsigned OP_XOR  = 2;
  localparam int unsigned OP_NOT  = 3;
  localparam int unsigned OP_ADD  = 4;
  localparam int unsigned OP_SUB  = 5;
  localparam int unsigned OP_NEG  = 6;
  localparam int unsigned OP_ASL  = 7;
  localparam int unsigned OP_LAST = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_is_legal(input int unsigned op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_dispatch_fifo.sv
// Command queue for alu_dispatch: power-of-two depth, wrapping pointers, unreset storage.
module alu_dispatch_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign dout  = mem[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/alu_dispatch.sv
// Queues ALU commands, drives a combinational ALU one command at a time and
// presents each captured result with flags on a valid/ready handshake.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int N     = 3,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [N:0] in_op,
  input  logic [N:0] in_a,
  input  logic [N:0] in_b,
  output logic [N:0] alu_op,
  output logic [N:0] alu_in1,
  output logic [N:0] alu_in2,
  input  logic [N:0] alu_result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [N:0] out_result,
  output logic       out_zero,
  output logic       out_neg,
  output logic       out_illegal
);

  localparam int W  = N + 1;
  localparam int CW = $clog2(DEPTH) + 1;

  state_t          state, state_nx;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [3*W-1:0]  fifo_dout;
  logic            do_capture, do_release;

  assign in_ready  = (fifo_count < CW'(DEPTH));
  assign fifo_push = in_valid & ~fifo_full;

  alu_dispatch_fifo #(
    .W     (3 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({in_op, in_a, in_b}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // The handshake edge in DONE doubles as the pop edge for the next command.
  always_comb begin
    state_nx   = state;
    fifo_pop   = 1'b0;
    do_capture = 1'b0;
    do_release = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: begin
        do_capture = 1'b1;
        state_nx   = DONE;
      end
      DONE: begin
        if (out_ready) begin
          do_release = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_nx = EXEC;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op      <= '0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_neg     <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      if (fifo_pop) {alu_op, alu_in1, alu_in2} <= fifo_dout;
      if (do_capture) begin
        out_valid <= 1'b1;
        if (op_is_legal(32'(alu_op))) begin
          out_result  <= alu_result;
          out_zero    <= (alu_result == '0);
          out_neg     <= alu_result[N];
          out_illegal <= 1'b0;
        end else begin
          out_result  <= '0;
          out_zero    <= 1'b0;
          out_neg     <= 1'b0;
          out_illegal <= 1'b1;
        end
      end else if (do_release) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch with a behavioural combinational ALU attached.
module tb_alu_dispatch;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [3:0] in_op, in_a, in_b;
  logic [3:0] alu_op, alu_in1, alu_in2, alu_result;
  logic       out_valid, out_ready;
  logic [3:0] out_result;
  logic       out_zero, out_neg, out_illegal;

  typedef struct {
    logic [3:0] res;
    logic       z;
    logic       n;
    logic       il;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pushes = 0;

  always #5 clk = ~clk;

  alu_dispatch #(.N(3), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .alu_op      (alu_op),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_result  (alu_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_neg     (out_neg),
    .out_illegal (out_illegal)
  );

  // Illegal opcodes return a nonzero, negative pattern so any leak is visible.
  always_comb begin
    alu_result = 4'hB;
    case (32'(alu_op))
      OP_AND:  alu_result = alu_in1 & alu_in2;
      OP_OR:   alu_result = alu_in1 | alu_in2;
      OP_XOR:  alu_result = alu_in1 ^ alu_in2;
      OP_NOT:  alu_result = ~alu_in1;
      OP_ADD:  alu_result = alu_in1 + alu_in2;
      OP_SUB:  alu_result = alu_in1 - alu_in2;
      OP_NEG:  alu_result = -alu_in1;
      OP_ASL:  alu_result = alu_in1 <<< 1;
      default: alu_result = 4'hB;
    endcase
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got %0h, expected none at %0t", out_result, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_result", 8'(out_result), 8'(e.res));
        chk("out_zero", 8'(out_zero), 8'(e.z));
        chk("out_neg", 8'(out_neg), 8'(e.n));
        chk("out_illegal", 8'(out_illegal), 8'(e.il));
      end
    end
  end

  task automatic push(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] r, input logic z, input logic n, input logic il);
    exp_t e;
    e.res = r; e.z = z; e.n = n; e.il = il;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pushes++;
        return;
      end
      tick(1);
    end
    in_valid = 1'b0;
    vectors++;
    miscompares++;
    $display("FAIL push_timeout: got in_ready=0, expected acceptance for op %0h", op);
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && !out_valid) return;
      tick(1);
    end
    vectors++;
    miscompares++;
    $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    tick(2);
    chk("rst_in_ready", 8'(in_ready), 8'd1);
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_out_result", 8'(out_result), 8'd0);
    chk("rst_flags", 8'({out_zero, out_neg, out_illegal}), 8'd0);
    chk("rst_alu", 8'({alu_op, alu_in1}), 8'd0);
    chk("rst_alu_in2", 8'(alu_in2), 8'd0);
    rst_n = 1'b1;
    tick(1);

    // ADD with latency: push edge, pop edge, capture edge.
    push(4'd4, 4'd3, 4'd4, 4'd7, 1'b0, 1'b0, 1'b0);
    chk("lat_after_push", 8'(out_valid), 8'd0);
    tick(1);
    chk("lat_after_pop", 8'(out_valid), 8'd0);
    tick(1);
    chk("lat_after_capture", 8'(out_valid), 8'd1);
    wait_drained();

    push(4'd5, 4'd2, 4'd5, 4'hD, 1'b0, 1'b1, 1'b0);
    push(4'd2, 4'd9, 4'd9, 4'h0, 1'b1, 1'b0, 1'b0);
    wait_drained();

    push(4'd9, 4'd1, 4'd1, 4'h0, 1'b0, 1'b0, 1'b1);
    push(4'd0, 4'hC, 4'hA, 4'h8, 1'b0, 1'b1, 1'b0);
    wait_drained();

    // Backpressure: one command parked in DONE, then fill the queue.
    out_ready = 1'b0;
    push(4'd1, 4'd5, 4'd2, 4'h7, 1'b0, 1'b0, 1'b0);
    tick(2);
    chk("stall_valid", 8'(out_valid), 8'd1);
    chk("stall_result", 8'(out_result), 8'h7);
    base = pushes;
    fork
      begin
        push(4'd3, 4'd5, 4'd1, 4'hA, 1'b0, 1'b1, 1'b0);
        push(4'd6, 4'd3, 4'd0, 4'hD, 1'b0, 1'b1, 1'b0);
        push(4'd7, 4'd9, 4'd0, 4'h2, 1'b0, 1'b0, 1'b0);
        push(4'd4, 4'd8, 4'd8, 4'h0, 1'b1, 1'b0, 1'b0);
        push(4'd0, 4'd6, 4'd3, 4'h2, 1'b0, 1'b0, 1'b0);
      end
      begin
        for (int i = 0; i < 30 && pushes < base + 4; i++) tick(1);
        chk("full_in_ready", 8'(in_ready), 8'd0);
        for (int i = 0; i < 5; i++) begin
          tick(1);
          chk("hold_valid", 8'(out_valid), 8'd1);
          chk("hold_result", 8'(out_result), 8'h7);
          chk("hold_flags", 8'({out_zero, out_neg, out_illegal}), 8'd0);
        end
        chk("fifth_blocked", 8'(pushes - base), 8'd4);
        out_ready = 1'b1;
        tick(1);
        chk("release_valid_low", 8'(out_valid), 8'd0);
        tick(1);
        chk("next_after_2", 8'(out_valid), 8'd1);
      end
    join
    wait_drained();

    // Reset while EXEC holds a command and two more are queued.
    out_ready = 1'b0;
    push(4'd4, 4'd1, 4'd1, 4'h2, 1'b0, 1'b0, 1'b0);
    push(4'd0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
    push(4'd1, 4'd1, 4'd2, 4'h3, 1'b0, 1'b0, 1'b0);
    push(4'd2, 4'd3, 4'd1, 4'h2, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick(1);
    chk("exec_before_rst", 8'(out_valid), 8'd0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_in_ready", 8'(in_ready), 8'd1);
    chk("midrst_out_valid", 8'(out_valid), 8'd0);
    chk("midrst_alu_op", 8'(alu_op), 8'd0);
    tick(2);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (out_valid) seen = 1'b1;
    end
    chk("no_output_after_rst", 8'(seen), 8'd0);

    push(4'd1, 4'd0, 4'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    push(4'd7, 4'hC, 4'd5, 4'h8, 1'b0, 1'b1, 1'b0);
    wait_drained();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
